// File: rtl/clockworks_pkg.sv
// Shared defaults and sizing helper for the clock/reset front end.
package clockworks_pkg;

  localparam int SLOW_DEF       = 24;
  localparam int RST_CYCLES_DEF = 4;

  // Width that can hold 0..rst_cycles inclusive.
  function automatic int stretch_w(input int rst_cycles);
    return $clog2(rst_cycles + 1);
  endfunction

endpackage

// File: rtl/clockworks_if.sv
// Design clock/reset bundle fanned out from the front end to the rest of the SoC.
interface clockworks_if;

  logic clk;
  logic resetn;

  modport master (output clk, output resetn);
  modport slave  (input  clk, input  resetn);

endinterface

// File: rtl/clockworks_reset_sync.sv
// 2-flop reset synchronizer: asserts asynchronously, releases on the 2nd clk_i rising edge.
module reset_sync (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], 1'b0};
    end
  end

  assign rst_o = sync_q[1];

endmodule

// File: rtl/clockworks_gen.sv
// Board clock/button to slow design clock (CLK / 2^(SLOW+1)) and stretched active-low reset.
module clockworks_gen
  import clockworks_pkg::*;
#(
  parameter int SLOW       = SLOW_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  clockworks_if.master  dom
);

  localparam int            DW   = SLOW + 1;
  localparam int            SW   = stretch_w(RST_CYCLES);
  localparam logic [SW-1:0] SMAX = SW'(RST_CYCLES);

  logic          rst_sync;
  logic [DW-1:0] div_q, div_d;
  logic          clk_q, clk_d;
  logic          rise;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          resetn_q, resetn_d;

  reset_sync u_reset_sync (
    .clk_i (CLK),
    .rst_i (RESET),
    .rst_o (rst_sync)
  );

  // clk is taken from the next divider value so it lines up with div itself.
  always_comb begin
    div_d    = div_q + DW'(1);
    clk_d    = div_d[SLOW];
    rise     = clk_d & ~clk_q;
    cnt_d    = cnt_q;
    resetn_d = resetn_q;
    if (rise && (cnt_q != SMAX)) begin
      cnt_d = cnt_q + SW'(1);
    end
    if (rise && (cnt_d == SMAX)) begin
      resetn_d = 1'b1;
    end
    if (rst_sync) begin
      div_d    = '0;
      clk_d    = 1'b0;
      rise     = 1'b0;
      cnt_d    = '0;
      resetn_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q    <= '0;
      clk_q    <= 1'b0;
      cnt_q    <= '0;
      resetn_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      clk_q    <= clk_d;
      cnt_q    <= cnt_d;
      resetn_q <= resetn_d;
    end
  end

  assign dom.clk    = clk_q;
  assign dom.resetn = resetn_q;

endmodule

// File: tb/tb_clockworks_gen.sv
// Directed bench for clockworks_gen: three parameterisations share CLK and RESET.
module tb_clockworks_gen;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  clockworks_if ia ();
  clockworks_if ib ();
  clockworks_if ic ();

  clockworks_gen #(.SLOW(2), .RST_CYCLES(4)) dut_a (.CLK(CLK), .RESET(RESET), .dom(ia));
  clockworks_gen #(.SLOW(3), .RST_CYCLES(4)) dut_b (.CLK(CLK), .RESET(RESET), .dom(ib));
  clockworks_gen #(.SLOW(0), .RST_CYCLES(1)) dut_c (.CLK(CLK), .RESET(RESET), .dom(ic));

  always #5 CLK = ~CLK;

  logic a_clk [1:64];
  logic a_rn  [1:64];
  logic b_clk [1:64];
  logic b_rn  [1:64];
  logic c_clk [1:64];
  logic c_rn  [1:64];

  // Index k holds the outputs just after the k-th CLK rising edge following release.
  task automatic sample_edges();
    for (int k = 1; k <= 64; k++) begin
      @(posedge CLK);
      #1;
      a_clk[k] = ia.clk; a_rn[k] = ia.resetn;
      b_clk[k] = ib.clk; b_rn[k] = ib.resetn;
      c_clk[k] = ic.clk; c_rn[k] = ic.resetn;
    end
  endtask

  function automatic int first_one(input logic v [1:64]);
    for (int k = 1; k <= 64; k++) begin
      if (v[k] === 1'b1) return k;
    end
    return 0;
  endfunction

  // Expected: low before edge `first`, then alternating phases of `half` edges starting high.
  function automatic int wave_errs(input logic v [1:64], input int first, input int half);
    int errs = 0;
    logic e;
    for (int k = 1; k <= 64; k++) begin
      e = (k >= first) && ((((k - first) / half) % 2) == 0);
      if (v[k] !== e) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset();
    #2 RESET = 1'b1;
    #1;
    n_tests++;
    if ({ia.clk, ia.resetn, ib.clk, ib.resetn, ic.clk, ic.resetn} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_assert: outputs=%b required 000000",
               {ia.clk, ia.resetn, ib.clk, ib.resetn, ic.clk, ic.resetn});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n_tests++;
      if ({ia.clk, ia.resetn, ib.clk, ib.resetn, ic.clk, ic.resetn} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: outputs=%b required 000000", i,
                 {ia.clk, ia.resetn, ib.clk, ib.resetn, ic.clk, ic.resetn});
      end
    end
  endtask

  task automatic test_startup();
    RESET = 1'b0;
    sample_edges();
    n_tests++;
    if (first_one(a_clk) !== 6) begin
      n_fail++; $display("FAIL startup_a_clk_rise: edge %0d required 6", first_one(a_clk));
    end
    n_tests++;
    if (wave_errs(a_clk, 6, 4) !== 0) begin
      n_fail++; $display("FAIL startup_a_clk_wave: %0d bad edges required 0", wave_errs(a_clk, 6, 4));
    end
    n_tests++;
    if (wave_errs(a_rn, 30, 1000) !== 0) begin
      n_fail++; $display("FAIL startup_a_resetn: first high edge %0d required 30", first_one(a_rn));
    end
    n_tests++;
    if (wave_errs(b_clk, 10, 8) !== 0) begin
      n_fail++; $display("FAIL startup_b_clk_wave: %0d bad edges, first rise %0d required 10",
                         wave_errs(b_clk, 10, 8), first_one(b_clk));
    end
    n_tests++;
    if (first_one(b_rn) !== 58) begin
      n_fail++; $display("FAIL startup_b_resetn: edge %0d required 58", first_one(b_rn));
    end
    n_tests++;
    if (wave_errs(c_clk, 3, 1) !== 0) begin
      n_fail++; $display("FAIL startup_c_clk_wave: %0d bad edges, first rise %0d required 3",
                         wave_errs(c_clk, 3, 1), first_one(c_clk));
    end
    n_tests++;
    if (wave_errs(c_rn, 3, 1000) !== 0) begin
      n_fail++; $display("FAIL startup_c_resetn: first high edge %0d required 3", first_one(c_rn));
    end
  endtask

  task automatic test_resetn_hold();
    int drops = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #1;
      if (ia.resetn !== 1'b1 || ib.resetn !== 1'b1 || ic.resetn !== 1'b1) drops++;
    end
    n_tests++;
    if (drops !== 0) begin
      n_fail++; $display("FAIL resetn_hold: %0d low samples required 0", drops);
    end
  endtask

  task automatic test_mid_reset();
    logic prev;
    int   t = 0;
    @(posedge CLK); #1;
    prev = ia.clk;
    while (!(prev === 1'b0 && ia.clk === 1'b1) && t < 50) begin
      prev = ia.clk;
      @(posedge CLK); #1;
      t++;
    end
    n_tests++;
    if (t >= 50) begin
      n_fail++; $display("FAIL mid_wait_rise: no a clk rise in %0d cycles required < 50", t);
    end
    @(posedge CLK); #1;
    n_tests++;
    if (ia.clk !== 1'b1 || ia.resetn !== 1'b1) begin
      n_fail++; $display("FAIL mid_precondition: clk=%b resetn=%b required 1 1", ia.clk, ia.resetn);
    end
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    n_tests++;
    if ({ia.clk, ia.resetn, ib.clk, ib.resetn, ic.clk, ic.resetn} !== 6'b0) begin
      n_fail++; $display("FAIL mid_assert: outputs=%b required 000000",
                         {ia.clk, ia.resetn, ib.clk, ib.resetn, ic.clk, ic.resetn});
    end
    @(negedge CLK);
    RESET = 1'b0;
    sample_edges();
    n_tests++;
    if (wave_errs(a_clk, 6, 4) !== 0) begin
      n_fail++; $display("FAIL mid_a_clk_wave: %0d bad edges, first rise %0d required 6",
                         wave_errs(a_clk, 6, 4), first_one(a_clk));
    end
    n_tests++;
    if (first_one(a_rn) !== 30) begin
      n_fail++; $display("FAIL mid_a_resetn: edge %0d required 30", first_one(a_rn));
    end
    n_tests++;
    if (first_one(c_rn) !== 3) begin
      n_fail++; $display("FAIL mid_c_resetn: edge %0d required 3", first_one(c_rn));
    end
  endtask

  task automatic test_glitch();
    @(posedge CLK);
    #1 RESET = 1'b1;
    #1;
    n_tests++;
    if ({ia.clk, ia.resetn, ib.clk, ib.resetn, ic.clk, ic.resetn} !== 6'b0) begin
      n_fail++; $display("FAIL glitch_assert: outputs=%b required 000000",
                         {ia.clk, ia.resetn, ib.clk, ib.resetn, ic.clk, ic.resetn});
    end
    #2 RESET = 1'b0;
    sample_edges();
    n_tests++;
    if (wave_errs(a_clk, 6, 4) !== 0) begin
      n_fail++; $display("FAIL glitch_a_clk_wave: %0d bad edges, first rise %0d required 6",
                         wave_errs(a_clk, 6, 4), first_one(a_clk));
    end
    n_tests++;
    if (first_one(a_rn) !== 30) begin
      n_fail++; $display("FAIL glitch_a_resetn: edge %0d required 30", first_one(a_rn));
    end
    n_tests++;
    if (first_one(b_rn) !== 58) begin
      n_fail++; $display("FAIL glitch_b_resetn: edge %0d required 58", first_one(b_rn));
    end
    n_tests++;
    if (wave_errs(c_clk, 3, 1) !== 0 || first_one(c_rn) !== 3) begin
      n_fail++; $display("FAIL glitch_c: %0d bad clk edges, resetn edge %0d required 0 and 3",
                         wave_errs(c_clk, 3, 1), first_one(c_rn));
    end
  endtask

  task automatic test_wrap();
    logic pb, pa;
    int   lb = 0, la = 0, runs_b = 0, runs_a = 0, bad_b = 0, bad_a = 0, drops = 0;
    bit   sb = 1'b0, sa = 1'b0;
    @(posedge CLK); #1;
    pb = ib.clk; pa = ia.clk;
    for (int i = 0; i < 1700; i++) begin
      @(posedge CLK); #1;
      if (ib.clk !== pb) begin
        if (sb) begin runs_b++; if (lb != 8) bad_b++; end
        sb = 1'b1; lb = 1; pb = ib.clk;
      end else lb++;
      if (ia.clk !== pa) begin
        if (sa) begin runs_a++; if (la != 4) bad_a++; end
        sa = 1'b1; la = 1; pa = ia.clk;
      end else la++;
      if (ia.resetn !== 1'b1 || ib.resetn !== 1'b1 || ic.resetn !== 1'b1) drops++;
    end
    n_tests++;
    if (bad_b !== 0 || runs_b < 200) begin
      n_fail++; $display("FAIL wrap_b_phases: %0d bad of %0d phases required 0 bad of >=200", bad_b, runs_b);
    end
    n_tests++;
    if (bad_a !== 0 || runs_a < 400) begin
      n_fail++; $display("FAIL wrap_a_phases: %0d bad of %0d phases required 0 bad of >=400", bad_a, runs_a);
    end
    n_tests++;
    if (drops !== 0) begin
      n_fail++; $display("FAIL wrap_resetn: %0d low samples required 0", drops);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t required finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_startup();
    test_resetn_hold();
    test_mid_reset();
    test_glitch();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
